// File: rtl/rgmii_rx_decoder_if.sv
// rtl/rgmii_rx_decoder_if.sv - RGMII receive pins and decoded byte stream
interface rgmii_rx_decoder_if;
  logic [3:0] rxd;
  logic       rx_ctl;
  logic       int_b;
  logic       mmcm_locked;
  logic [7:0] data;
  logic       valid;
  logic       last;

  modport master (
    output rxd, rx_ctl, int_b, mmcm_locked,
    input  data, valid, last
  );

  modport slave (
    input  rxd, rx_ctl, int_b, mmcm_locked,
    output data, valid, last
  );
endinterface

// File: rtl/rgmii_rx_decoder.sv
// rtl/rgmii_rx_decoder.sv - RGMII DDR receive decoder producing a framed byte stream
module rgmii_rx_decoder (
  input  logic                rx_clk,
  input  logic                rst,
  rgmii_rx_decoder_if.slave   bus
);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, RECV} state_t;

  logic [3:0] rise_d;
  logic       rise_ctl;
  logic [3:0] fall_d;
  logic       fall_ctl;
  logic [7:0] byte_q;
  logic       dv_q;
  logic       er_q;
  logic [1:0] prime;

  state_t     state, state_d;
  logic [7:0] hold, hold_d;
  logic [7:0] data_r, data_d;
  logic       valid_r, valid_d;
  logic       last_r, last_d;

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      rise_d   <= '0;
      rise_ctl <= 1'b0;
    end else begin
      rise_d   <= bus.rxd;
      rise_ctl <= bus.rx_ctl;
    end
  end

  always_ff @(negedge rx_clk or posedge rst) begin
    if (rst) begin
      fall_d   <= '0;
      fall_ctl <= 1'b0;
    end else begin
      fall_d   <= bus.rxd;
      fall_ctl <= bus.rx_ctl;
    end
  end

  // prime[1] marks dv_q as coming from a real sample rather than the reset value,
  // so a frame already in progress at reset release is not mistaken for idle.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      byte_q <= '0;
      dv_q   <= 1'b0;
      er_q   <= 1'b0;
      prime  <= '0;
    end else begin
      byte_q <= {fall_d, rise_d};
      dv_q   <= rise_ctl;
      er_q   <= rise_ctl ^ fall_ctl;
      prime  <= {prime[0], 1'b1};
    end
  end

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      state   <= WAIT_IDLE;
      hold    <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      state   <= state_d;
      hold    <= hold_d;
      data_r  <= data_d;
      valid_r <= valid_d;
      last_r  <= last_d;
    end
  end

  // The held byte is only released once the following cycle's dv is known,
  // which lets last land on the final byte itself.
  always_comb begin
    state_d = state;
    hold_d  = hold;
    data_d  = data_r;
    valid_d = 1'b0;
    last_d  = 1'b0;
    if (!bus.mmcm_locked) begin
      state_d = WAIT_IDLE;
    end else begin
      case (state)
        WAIT_IDLE: begin
          if (prime[1] && !dv_q) state_d = IDLE;
        end
        IDLE: begin
          if (dv_q) begin
            hold_d  = byte_q;
            state_d = RECV;
          end
        end
        RECV: begin
          data_d  = hold;
          valid_d = 1'b1;
          if (dv_q) begin
            hold_d = byte_q;
          end else begin
            last_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = WAIT_IDLE;
      endcase
    end
  end

  assign bus.data  = data_r;
  assign bus.valid = valid_r;
  assign bus.last  = last_r;

  // Errored bytes are forwarded unchanged; the interrupt pin is informational only.
  logic unused;
  assign unused = &{1'b0, er_q, bus.int_b};

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// tb/tb_rgmii_rx_decoder.sv - randomized self-checking bench for rgmii_rx_decoder
module tb_rgmii_rx_decoder;
  logic clk = 1'b0;
  logic rst;
  rgmii_rx_decoder_if bus();

  rgmii_rx_decoder dut (.rx_clk(clk), .rst(rst), .bus(bus));

  always #4 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int sample_cyc = 0;
  int orphan_last = 0;

  logic [7:0] got_data[$];
  logic       got_last[$];
  int         got_cyc[$];
  logic [7:0] exp_data[$];
  logic       exp_last[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      got_data.push_back(bus.data);
      got_last.push_back(bus.last);
      got_cyc.push_back(cyc);
    end else if (bus.last !== 1'b0) begin
      orphan_last++;
    end
  end

  // One RGMII cycle: low nibble and dv before the rising edge, high nibble and dv^er before the falling edge.
  task automatic drive(input logic [7:0] b, input logic dv, input logic er);
    bus.rxd    = b[3:0];
    bus.rx_ctl = dv;
    @(posedge clk);
    #1;
    sample_cyc = cyc;
    bus.rxd    = b[7:4];
    bus.rx_ctl = dv ^ er;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'($urandom), 1'b0, 1'($urandom));
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int er_idx);
    for (int i = 0; i < f.size(); i++) drive(f[i], 1'b1, i == er_idx);
  endtask

  // Reference: every dv=1 byte of an accepted frame, last only on its final byte.
  task automatic model_frame(input logic [7:0] f[$], input int keep);
    for (int i = 0; i < keep; i++) begin
      exp_data.push_back(f[i]);
      exp_last.push_back(keep == f.size() && i == f.size() - 1);
    end
  endtask

  task automatic clear_all();
    got_data.delete(); got_last.delete(); got_cyc.delete();
    exp_data.delete(); exp_last.delete();
  endtask

  task automatic rand_frame(output logic [7:0] f[$], input int len);
    f.delete();
    for (int i = 0; i < len; i++) f.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rxd = 4'h0; bus.rx_ctl = 1'b0; bus.int_b = 1'bx; bus.mmcm_locked = 1'b0;
    #20;
    total_cnt++; if (bus.valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.valid); else pass_cnt++;
    total_cnt++; if (bus.last !== 1'b0) $display("FAIL reset_last got %b want 0", bus.last); else pass_cnt++;
    total_cnt++; if (bus.data !== 8'h00) $display("FAIL reset_data got %h want 00", bus.data); else pass_cnt++;
    @(negedge clk); #1;
    rst = 1'b0;
    idle(3);
  endtask

  task automatic test_long_frame();
    logic [7:0] f[$];
    int s0;
    clear_all();
    bus.mmcm_locked = 1'b1;
    idle(3);
    for (int i = 0; i < 1440; i++) f.push_back(8'(i));
    for (int i = 0; i < f.size(); i++) begin
      drive(f[i], 1'b1, 1'b0);
      if (i == 0) s0 = sample_cyc;
    end
    model_frame(f, f.size());
    idle(6);
    total_cnt++; if (got_data.size() !== 1440) $display("FAIL long_count got %0d want 1440", got_data.size()); else pass_cnt++;
    for (int i = 0; i < exp_data.size(); i++) begin
      total_cnt++;
      if ({got_data[i], got_last[i]} !== {exp_data[i], exp_last[i]} || got_cyc[i] !== s0 + 3 + i)
        $display("FAIL long_byte[%0d] got %h/%b@%0d want %h/%b@%0d", i, got_data[i], got_last[i], got_cyc[i], exp_data[i], exp_last[i], s0 + 3 + i);
      else pass_cnt++;
    end
    total_cnt++; if (got_data[1439] !== 8'h9F) $display("FAIL long_final got %h want 9f", got_data[1439]); else pass_cnt++;
  endtask

  task automatic test_single_byte();
    int s0;
    clear_all();
    drive(8'hA5, 1'b1, 1'b0);
    s0 = sample_cyc;
    idle(6);
    total_cnt++; if (got_data.size() !== 1) $display("FAIL single_count got %0d want 1", got_data.size()); else pass_cnt++;
    total_cnt++;
    if ({got_data[0], got_last[0]} !== {8'hA5, 1'b1} || got_cyc[0] !== s0 + 3)
      $display("FAIL single_byte got %h/%b@%0d want a5/1@%0d", got_data[0], got_last[0], got_cyc[0], s0 + 3);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a[$], b[$];
    clear_all();
    a = '{8'h01, 8'h02, 8'h03, 8'h04};
    b = '{8'h11, 8'h12, 8'h13, 8'h14};
    send_frame(a, -1); idle(1); send_frame(b, -1); idle(6);
    model_frame(a, a.size()); model_frame(b, b.size());
    total_cnt++; if (got_data.size() !== 8) $display("FAIL b2b_count got %0d want 8", got_data.size()); else pass_cnt++;
    for (int i = 0; i < exp_data.size(); i++) begin
      total_cnt++;
      if ({got_data[i], got_last[i]} !== {exp_data[i], exp_last[i]})
        $display("FAIL b2b_byte[%0d] got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_lock();
    logic [7:0] f[$], g[$], h[$];
    clear_all();
    // Unlocked start, lock rises mid-frame: the whole frame is dropped.
    bus.mmcm_locked = 1'b0;
    rand_frame(f, 16);
    for (int i = 0; i < 16; i++) begin
      drive(f[i], 1'b1, 1'b0);
      if (i == 7) bus.mmcm_locked = 1'b1;
    end
    idle(2);
    rand_frame(g, 10);
    send_frame(g, -1); idle(2);
    model_frame(g, g.size());
    // Lock drops after byte 9 is sampled: only bytes whose 3-edge latency has elapsed appear, no last.
    rand_frame(h, 20);
    for (int i = 0; i < 10; i++) drive(h[i], 1'b1, 1'b0);
    bus.mmcm_locked = 1'b0;
    model_frame(h, 10 - 3);
    for (int i = 10; i < 20; i++) drive(h[i], 1'b1, 1'b0);
    bus.mmcm_locked = 1'b1;
    idle(6);
    total_cnt++; if (got_data.size() !== exp_data.size()) $display("FAIL lock_count got %0d want %0d", got_data.size(), exp_data.size()); else pass_cnt++;
    for (int i = 0; i < exp_data.size(); i++) begin
      total_cnt++;
      if ({got_data[i], got_last[i]} !== {exp_data[i], exp_last[i]})
        $display("FAIL lock_byte[%0d] got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] f[$], g[$];
    clear_all();
    rand_frame(f, 130);
    for (int i = 0; i < 100; i++) drive(f[i], 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    total_cnt++; if (bus.valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", bus.valid); else pass_cnt++;
    total_cnt++; if (bus.last !== 1'b0) $display("FAIL rstmid_last got %b want 0", bus.last); else pass_cnt++;
    total_cnt++; if (bus.data !== 8'h00) $display("FAIL rstmid_data got %h want 00", bus.data); else pass_cnt++;
    model_frame(f, 100 - 3);
    for (int i = 100; i < 103; i++) drive(f[i], 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 103; i < 130; i++) drive(f[i], 1'b1, 1'b0);
    idle(1);
    rand_frame(g, 12);
    send_frame(g, -1); idle(6);
    model_frame(g, g.size());
    total_cnt++; if (got_data.size() !== exp_data.size()) $display("FAIL rstmid_count got %0d want %0d", got_data.size(), exp_data.size()); else pass_cnt++;
    for (int i = 0; i < exp_data.size(); i++) begin
      total_cnt++;
      if ({got_data[i], got_last[i]} !== {exp_data[i], exp_last[i]})
        $display("FAIL rstmid_byte[%0d] got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_rx_er();
    logic [7:0] f[$];
    clear_all();
    rand_frame(f, 8);
    send_frame(f, 5); idle(6);
    model_frame(f, f.size());
    total_cnt++; if (got_data.size() !== 8) $display("FAIL er_count got %0d want 8", got_data.size()); else pass_cnt++;
    for (int i = 0; i < exp_data.size(); i++) begin
      total_cnt++;
      if ({got_data[i], got_last[i]} !== {exp_data[i], exp_last[i]})
        $display("FAIL er_byte[%0d] got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] f[$];
    int er_idx;
    clear_all();
    for (int n = 0; n < 8; n++) begin
      rand_frame(f, $urandom_range(1, 48));
      er_idx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, f.size() - 1)) : -1;
      send_frame(f, er_idx);
      model_frame(f, f.size());
      idle($urandom_range(1, 3));
    end
    idle(6);
    total_cnt++; if (got_data.size() !== exp_data.size()) $display("FAIL rand_count got %0d want %0d", got_data.size(), exp_data.size()); else pass_cnt++;
    for (int i = 0; i < exp_data.size(); i++) begin
      total_cnt++;
      if ({got_data[i], got_last[i]} !== {exp_data[i], exp_last[i]})
        $display("FAIL rand_byte[%0d] got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      else pass_cnt++;
    end
    total_cnt++; if (orphan_last !== 0) $display("FAIL orphan_last got %0d want 0", orphan_last); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_long_frame();
    test_single_byte();
    test_back_to_back();
    test_lock();
    test_reset_mid_frame();
    test_rx_er();
    test_random_frames();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
